// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: shift modes and controller states.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_ASR = 2'b00,
    MODE_LSR = 2'b01,
    MODE_LSL = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational shift of a word by k positions (0..STEP) in one of four modes,
// also returning the OR of every bit that fell off the end.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] word,
  input  logic [KW-1:0]    k,
  input  mode_e            mode,
  output logic [WIDTH-1:0] shifted,
  output logic             lost
);

  // Unrolled as STEP single-bit stages, each enabled only while i < k.
  always_comb begin
    shifted = word;
    lost    = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (i < 32'(k)) begin
        case (mode)
          MODE_ASR: begin
            lost    = lost | shifted[0];
            shifted = {shifted[WIDTH-1], shifted[WIDTH-1:1]};
          end
          MODE_LSR: begin
            lost    = lost | shifted[0];
            shifted = {1'b0, shifted[WIDTH-1:1]};
          end
          MODE_LSL: begin
            lost    = lost | shifted[WIDTH-1];
            shifted = {shifted[WIDTH-2:0], 1'b0};
          end
          default: begin
            shifted = {shifted[0], shifted[WIDTH-1:1]};
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter with start/busy/ready handshake, moving up to STEP bits per clock.
// Define ITERATIVE_SHIFTER_STICKY_EN to build the sticky (OR of shifted-out bits) logic.
module iterative_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH   = 11,
  parameter int STEP    = 1,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data,
  output logic [WIDTH-1:0]   out,
  output logic               busy,
  output logic               ready,
  output logic               sticky
);

  localparam int RW = $clog2(WIDTH + 1);
  localparam int KW = $clog2(STEP + 1);

  state_e           state, next_state;
  logic [WIDTH-1:0] work, step_word;
  mode_e            wmode;
  logic [RW-1:0]    remaining, n_eff;
  logic [KW-1:0]    k;
  logic             step_or;
  logic             last;

  // Amounts at or beyond WIDTH saturate; that alone gives the required
  // all-sign / zero / unchanged results for each mode.
  always_comb begin
    if (32'(shamt) >= WIDTH) n_eff = RW'(WIDTH);
    else                     n_eff = RW'(shamt);
    if (remaining < RW'(STEP)) k = KW'(remaining);
    else                       k = KW'(STEP);
    last = (state == SHIFT) && (remaining == RW'(k));
  end

  shift_step #(.WIDTH(WIDTH), .STEP(STEP), .KW(KW)) u_step (
    .word    (work),
    .k       (k),
    .mode    (wmode),
    .shifted (step_word),
    .lost    (step_or)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (n_eff == '0) ? DONE : SHIFT;
      SHIFT:   if (last)  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    ready = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work      <= '0;
      wmode     <= MODE_ASR;
      remaining <= '0;
      out       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work      <= data;
            wmode     <= mode_e'(mode);
            remaining <= n_eff;
            if (n_eff == '0) out <= data;
          end
        end
        SHIFT: begin
          work      <= step_word;
          remaining <= remaining - RW'(k);
          if (last) out <= step_word;
        end
        default: ;
      endcase
    end
  end

`ifdef ITERATIVE_SHIFTER_STICKY_EN
  logic sticky_acc, sticky_r;

  // The accumulator runs privately; the visible flag only moves with out.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_acc <= 1'b0;
      sticky_r   <= 1'b0;
    end else if (state == IDLE && start) begin
      sticky_acc <= 1'b0;
      if (n_eff == '0) sticky_r <= 1'b0;
    end else if (state == SHIFT) begin
      sticky_acc <= sticky_acc | step_or;
      if (last) sticky_r <= sticky_acc | step_or;
    end
  end

  assign sticky = sticky_r;
`else
  logic step_or_unused;
  assign step_or_unused = step_or;
  assign sticky         = 1'b0;
`endif

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter: STEP=1 and STEP=4 instances, queue scoreboard.
// Sticky expectations follow ITERATIVE_SHIFTER_STICKY_EN.
module tb_iterative_shifter;

  localparam int W = 11;
`ifdef ITERATIVE_SHIFTER_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] out;
    logic         sticky;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start1, start4;
  logic [1:0]   mode;
  logic [3:0]   shamt;
  logic [W-1:0] data;
  logic [W-1:0] out1, out4;
  logic         busy1, ready1, sticky1, busy4, ready4, sticky4;

  exp_t q1[$];
  exp_t q4[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;

  iterative_shifter #(.WIDTH(W), .STEP(1), .SHAMT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .shamt(shamt), .data(data),
    .out(out1), .busy(busy1), .ready(ready1), .sticky(sticky1)
  );

  iterative_shifter #(.WIDTH(W), .STEP(4), .SHAMT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode), .shamt(shamt), .data(data),
    .out(out4), .busy(busy4), .ready(ready4), .sticky(sticky4)
  );

  function automatic exp_t mk(logic [W-1:0] o, logic s, int lat);
    exp_t e;
    e.out = o; e.sticky = s; e.lat = lat;
    return e;
  endfunction

  // Reference: one-shot shift on double-width words, independent of the stepping.
  function automatic exp_t model(logic [W-1:0] d, logic [1:0] m, int sh, int st);
    logic [2*W-1:0] wide, one, mask;
    logic [W-1:0]   res;
    logic           lost;
    int             n;
    n    = (sh > W) ? W : sh;
    one  = 1;
    mask = (one << n) - one;
    lost = |({{W{1'b0}}, d} & mask);
    case (m)
      2'b00: begin wide = {{W{d[W-1]}}, d} >> n; res = wide[W-1:0]; end
      2'b01: begin wide = {{W{1'b0}}, d} >> n;   res = wide[W-1:0]; end
      2'b10: begin wide = {{W{1'b0}}, d} << n;   res = wide[W-1:0]; lost = |wide[2*W-1:W]; end
      default: begin wide = {d, d} >> n;         res = wide[W-1:0]; lost = 1'b0; end
    endcase
    return mk(res, STICKY & lost, 1 + (n + st - 1) / st);
  endfunction

  task automatic issue(input bit sel, input logic [W-1:0] d, input logic [1:0] m,
                       input logic [3:0] s, input exp_t e);
    @(negedge clk);
    data = d; mode = m; shamt = s;
    if (sel) begin start4 = 1'b1; q4.push_back(e); end
    else     begin start1 = 1'b1; q1.push_back(e); end
  endtask

  task automatic wait_ready(input bit sel, output int edges, output int busy_cycles, output bit ok);
    edges = 0; busy_cycles = 0; ok = 1'b0;
    while (!ok && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
      if (sel ? busy4 : busy1) busy_cycles++;
      if (sel ? ready4 : ready1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b1; start4 = 1'b1; mode = 2'b00; shamt = 4'd3; data = 11'h480;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    n_compared++;
    if ({out1, busy1, ready1, sticky1} !== {{W{1'b0}}, 3'b000}) begin
      n_mismatched++;
      $display("[TB] FAIL reset_dut: got out=%h busy=%b ready=%b sticky=%b want all 0", out1, busy1, ready1, sticky1);
    end
    n_compared++;
    if ({out4, busy4, ready4, sticky4} !== {{W{1'b0}}, 3'b000}) begin
      n_mismatched++;
      $display("[TB] FAIL reset_dut4: got out=%h busy=%b ready=%b sticky=%b want all 0", out4, busy4, ready4, sticky4);
    end
    rst = 1'b0;
    @(negedge clk);
    n_compared++;
    if (busy1 !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_override: got busy=%b want 0", busy1);
    end
  endtask

  task automatic test_asr();
    int edges, bc; bit ok; exp_t e;
    issue(1'b0, 11'h480, 2'b00, 4'd3, mk(11'h790, 1'b0, 4));
    wait_ready(1'b0, edges, bc, ok);
    e = q1.pop_front();
    n_compared++;
    if (!ok) begin n_mismatched++; $display("[TB] FAIL asr_timeout: no ready within %0d edges", edges); end
    n_compared++;
    if (out1 !== e.out || sticky1 !== e.sticky) begin
      n_mismatched++;
      $display("[TB] FAIL asr_result: got %h/%b want %h/%b", out1, sticky1, e.out, e.sticky);
    end
    n_compared++;
    if (edges !== e.lat || bc !== 4) begin
      n_mismatched++;
      $display("[TB] FAIL asr_timing: got lat=%0d busy=%0d want lat=%0d busy=4", edges, bc, e.lat);
    end
    @(negedge clk);
    n_compared++;
    if (ready1 !== 1'b0 || out1 !== 11'h790 || busy1 !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL asr_hold: got ready=%b busy=%b out=%h want 0/0/790", ready1, busy1, out1);
    end
  endtask

  task automatic test_modes();
    int edges, bc; bit ok; exp_t e;
    exp_t plan[3];
    logic [W-1:0] pd[3];
    logic [1:0]   pm[3];
    logic [3:0]   ps[3];
    pd[0] = 11'h405; pm[0] = 2'b01; ps[0] = 4'd2;  plan[0] = mk(11'h101, STICKY, 3);
    pd[1] = 11'h7FF; pm[1] = 2'b10; ps[1] = 4'd15; plan[1] = mk(11'h000, STICKY, 12);
    pd[2] = 11'h001; pm[2] = 2'b11; ps[2] = 4'd1;  plan[2] = mk(11'h400, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, pd[i], pm[i], ps[i], plan[i]);
      wait_ready(1'b0, edges, bc, ok);
      e = q1.pop_front();
      n_compared++;
      if (!ok || edges !== e.lat) begin
        n_mismatched++;
        $display("[TB] FAIL mode%0d_latency: got %0d (ready=%b) want %0d", i, edges, ok, e.lat);
      end
      n_compared++;
      if (out1 !== e.out || sticky1 !== e.sticky) begin
        n_mismatched++;
        $display("[TB] FAIL mode%0d_result: got %h/%b want %h/%b", i, out1, sticky1, e.out, e.sticky);
      end
    end
  endtask

  task automatic test_zero_and_ignore();
    int pulses, edges, bc; bit ok; exp_t e;
    issue(1'b0, 11'h2AB, 2'b01, 4'd0, mk(11'h2AB, 1'b0, 1));
    @(posedge clk);
    @(negedge clk);
    e = q1.pop_front();
    n_compared++;
    if (ready1 !== 1'b1 || out1 !== e.out || sticky1 !== e.sticky) begin
      n_mismatched++;
      $display("[TB] FAIL zero_shift: got ready=%b out=%h/%b want 1 %h/%b", ready1, out1, sticky1, e.out, e.sticky);
    end
    data = 11'h155; shamt = 4'd2;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      if (ready1) pulses++;
    end
    n_compared++;
    if (pulses !== 0 || out1 !== 11'h2AB) begin
      n_mismatched++;
      $display("[TB] FAIL start_in_done: got pulses=%0d out=%h want 0 2AB", pulses, out1);
    end
    // Start and input changes during SHIFT must not disturb the running op.
    issue(1'b0, 11'h480, 2'b00, 4'd3, mk(11'h790, 1'b0, 4));
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b1; data = 11'h000; mode = 2'b10; shamt = 4'd7;
    wait_ready(1'b0, edges, bc, ok);
    e = q1.pop_front();
    pulses = ok ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready1) pulses++;
    end
    n_compared++;
    if (pulses !== 1 || out1 !== e.out || edges !== e.lat - 1) begin
      n_mismatched++;
      $display("[TB] FAIL start_in_shift: got pulses=%0d out=%h lat=%0d want 1 %h %0d", pulses, out1, edges + 1, e.out, e.lat);
    end
  endtask

  task automatic test_step4();
    int edges, bc; bit ok; exp_t e;
    issue(1'b1, 11'h400, 2'b00, 4'd10, mk(11'h7FF, 1'b0, 4));
    wait_ready(1'b1, edges, bc, ok);
    e = q4.pop_front();
    n_compared++;
    if (!ok || edges !== e.lat || bc !== 4) begin
      n_mismatched++;
      $display("[TB] FAIL step4_timing: got lat=%0d busy=%0d want %0d 4", edges, bc, e.lat);
    end
    n_compared++;
    if (out4 !== e.out || sticky4 !== e.sticky) begin
      n_mismatched++;
      $display("[TB] FAIL step4_result: got %h/%b want %h/%b", out4, sticky4, e.out, e.sticky);
    end
  endtask

  task automatic test_abort();
    int pulses, edges, bc; bit ok; exp_t e;
    issue(1'b0, 11'h3C3, 2'b01, 4'd5, mk(11'h000, 1'b0, 0));
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q1.delete();
    n_compared++;
    if (out1 !== '0 || busy1 !== 1'b0 || ready1 !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_state: got out=%h busy=%b ready=%b want 0/0/0", out1, busy1, ready1);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready1) pulses++;
    end
    n_compared++;
    if (pulses !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_ready: got %0d pulses want 0", pulses);
    end
    issue(1'b0, 11'h3C3, 2'b01, 4'd5, model(11'h3C3, 2'b01, 5, 1));
    wait_ready(1'b0, edges, bc, ok);
    e = q1.pop_front();
    n_compared++;
    if (!ok || edges !== e.lat || out1 !== e.out || sticky1 !== e.sticky) begin
      n_mismatched++;
      $display("[TB] FAIL abort_recover: got lat=%0d out=%h/%b want %0d %h/%b", edges, out1, sticky1, e.lat, e.out, e.sticky);
    end
  endtask

  task automatic test_random();
    int edges, bc; bit ok, sel; exp_t e;
    logic [W-1:0] d; logic [1:0] m; logic [3:0] s;
    logic [W-1:0] got; logic gs;
    for (int i = 0; i < 24; i++) begin
      sel = (i % 2) == 1;
      d = W'($urandom); m = 2'($urandom_range(0, 3)); s = 4'($urandom_range(0, 15));
      issue(sel, d, m, s, model(d, m, int'(s), sel ? 4 : 1));
      wait_ready(sel, edges, bc, ok);
      e   = sel ? q4.pop_front() : q1.pop_front();
      got = sel ? out4 : out1;
      gs  = sel ? sticky4 : sticky1;
      n_compared++;
      if (!ok || edges !== e.lat || got !== e.out || gs !== e.sticky) begin
        n_mismatched++;
        $display("[TB] FAIL random%0d (step%0d d=%h m=%0d s=%0d): got lat=%0d out=%h/%b want %0d %h/%b",
                 i, sel ? 4 : 1, d, m, s, edges, got, gs, e.lat, e.out, e.sticky);
      end
    end
  endtask

  initial begin
    test_reset();
    test_asr();
    test_modes();
    test_zero_and_ignore();
    test_step4();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
